// File: rtl/gray_decoder_if.sv
// ---------------------------------------------------------------------------
// gray_decoder_if
//   Bundles the sample stream and the decoded status of gray_decoder.
//
//   Valid    : sample strobe (source -> decoder)
//   Gray     : Gray-coded sample (source -> decoder)
//   Binary   : registered decoded value of the last accepted sample
//   Step     : one-cycle pulse, last sample was a legal forward step
//   Error    : one-cycle pulse, last sample was an illegal transition
//   Wraps    : saturating count of max->0 wraps
//   ErrCnt   : saturating count of illegal transitions
//   Overflow : sticky, set on the first wrap since reset
//   Locked   : a baseline sample has been taken
//
//   master : the Gray source / observer side
//   slave  : the decoder side
// ---------------------------------------------------------------------------
interface gray_decoder_if #(
   parameter int unsigned WIDTH      = 3,
   parameter int unsigned WRAP_WIDTH = 3,
   parameter int unsigned ERR_WIDTH  = 4
);
   logic                  Valid;
   logic [WIDTH-1:0]      Gray;
   logic [WIDTH-1:0]      Binary;
   logic                  Step;
   logic                  Error;
   logic [WRAP_WIDTH-1:0] Wraps;
   logic [ERR_WIDTH-1:0]  ErrCnt;
   logic                  Overflow;
   logic                  Locked;

   modport master (
      output Valid, Gray,
      input  Binary, Step, Error, Wraps, ErrCnt, Overflow, Locked
   );

   modport slave (
      input  Valid, Gray,
      output Binary, Step, Error, Wraps, ErrCnt, Overflow, Locked
   );
endinterface

// File: rtl/gray_decoder.sv
// ---------------------------------------------------------------------------
// gray_decoder
//   Samples a Gray-coded count stream, decodes it to binary and checks that
//   each accepted code is exactly one forward step from the previous one.
//   Counts wrap-arounds (max -> 0) and illegal transitions, both saturating.
//   All outputs are registered: response appears the cycle after sampling.
//
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous reset, active low
//   bus   : gray_decoder_if.slave (Valid/Gray in, status out)
// ---------------------------------------------------------------------------
module gray_decoder #(
   parameter int unsigned WIDTH      = 3,
   parameter int unsigned WRAP_WIDTH = 3,
   parameter int unsigned ERR_WIDTH  = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   gray_decoder_if.slave   bus
);

   typedef enum logic {
      IDLE,
      TRACK
   } state_t;

   state_t                state_q,    state_d;
   logic [WIDTH-1:0]      binary_q,   binary_d;
   logic                  step_q,     step_d;
   logic                  error_q,    error_d;
   logic [WRAP_WIDTH-1:0] wraps_q,    wraps_d;
   logic [ERR_WIDTH-1:0]  errcnt_q,   errcnt_d;
   logic                  overflow_q, overflow_d;

   logic [WIDTH-1:0]      dec;
   logic [WIDTH-1:0]      delta;
   logic                  is_wrap;

   // Binary bit i is the XOR of Gray bits i..MSB; this is the same as the
   // MSB-down prefix chain but without a self-referencing loop.
   always_comb begin
      dec = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         dec[i] = ^(bus.Gray >> i);
      end
   end

   // Modular distance from the last accepted value to the new sample.
   assign delta   = dec - binary_q;
   assign is_wrap = (binary_q == '1) && (dec == '0);

   always_comb begin
      state_d    = state_q;
      binary_d   = binary_q;
      step_d     = 1'b0;
      error_d    = 1'b0;
      wraps_d    = wraps_q;
      errcnt_d   = errcnt_q;
      overflow_d = overflow_q;

      unique case (state_q)
         IDLE: begin
            if (bus.Valid) begin
               binary_d = dec;
               state_d  = TRACK;
            end
         end

         TRACK: begin
            if (bus.Valid) begin
               if (delta == '0) begin
                  // Repeated code: nothing changes, not an error.
               end else if (delta == WIDTH'(1)) begin
                  binary_d = dec;
                  step_d   = 1'b1;
                  if (is_wrap) begin
                     overflow_d = 1'b1;
                     if (wraps_q != '1) begin
                        wraps_d = wraps_q + 1'b1;
                     end
                  end
               end else begin
                  // Resync to the new value; no wrap is counted here even
                  // if the jump crosses zero.
                  binary_d = dec;
                  error_d  = 1'b1;
                  if (errcnt_q != '1) begin
                     errcnt_d = errcnt_q + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q    <= IDLE;
         binary_q   <= '0;
         step_q     <= 1'b0;
         error_q    <= 1'b0;
         wraps_q    <= '0;
         errcnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         binary_q   <= binary_d;
         step_q     <= step_d;
         error_q    <= error_d;
         wraps_q    <= wraps_d;
         errcnt_q   <= errcnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.Binary   = binary_q;
   assign bus.Step     = step_q;
   assign bus.Error    = error_q;
   assign bus.Wraps    = wraps_q;
   assign bus.ErrCnt   = errcnt_q;
   assign bus.Overflow = overflow_q;
   assign bus.Locked   = (state_q == TRACK);

endmodule

// File: tb/tb_gray_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_decoder
//   Directed self-checking bench for gray_decoder (WIDTH=3, WRAP_WIDTH=3,
//   ERR_WIDTH=4). Inputs change on the falling edge; outputs are checked
//   1 time unit after the rising edge that samples them.
// ---------------------------------------------------------------------------
module tb_gray_decoder;

   logic Clk;
   logic Reset;

   int unsigned n_tests;
   int unsigned n_fail;

   gray_decoder_if #(
      .WIDTH      (3),
      .WRAP_WIDTH (3),
      .ERR_WIDTH  (4)
   ) bus ();

   gray_decoder #(
      .WIDTH      (3),
      .WRAP_WIDTH (3),
      .ERR_WIDTH  (4)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Gray codes for binary 0..7, then 0 again.
   logic [2:0] gseq [0:8];

   task automatic cyc(input logic rst_n, input logic v, input logic [2:0] g);
      @(negedge Clk);
      Reset     = rst_n;
      bus.Valid = v;
      bus.Gray  = g;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] bin, input logic st,
                          input logic er, input logic [2:0] wr, input logic [3:0] ec,
                          input logic ov, input logic lk);
      chk({tag, ".Binary"},   32'(bus.Binary),   32'(bin));
      chk({tag, ".Step"},     32'(bus.Step),     32'(st));
      chk({tag, ".Error"},    32'(bus.Error),    32'(er));
      chk({tag, ".Wraps"},    32'(bus.Wraps),    32'(wr));
      chk({tag, ".ErrCnt"},   32'(bus.ErrCnt),   32'(ec));
      chk({tag, ".Overflow"}, 32'(bus.Overflow), 32'(ov));
      chk({tag, ".Locked"},   32'(bus.Locked),   32'(lk));
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
      gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;
      gseq[8] = 3'b000;
      Reset     = 1'b0;
      bus.Valid = 1'b0;
      bus.Gray  = 3'b000;

      // Reset state
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b0, 1'b0, 3'b000);
      chk_all("reset", 3'd0, 0, 0, 3'd0, 4'd0, 0, 0);

      // Idle with no Valid stays unlocked
      cyc(1'b1, 1'b0, 3'b101);
      chk_all("idle_hold", 3'd0, 0, 0, 3'd0, 4'd0, 0, 0);

      // Full forward sequence with one wrap
      cyc(1'b1, 1'b1, gseq[0]);
      chk_all("fwd_base", 3'd0, 0, 0, 3'd0, 4'd0, 0, 1);
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b1, 1'b1, gseq[i]);
         chk_all($sformatf("fwd_%0d", i), 3'(i), 1, 0, 3'd0, 4'd0, 0, 1);
      end
      cyc(1'b1, 1'b1, gseq[8]);
      chk_all("fwd_wrap", 3'd0, 1, 0, 3'd1, 4'd0, 1, 1);
      cyc(1'b1, 1'b0, 3'b000);
      chk_all("fwd_after", 3'd0, 0, 0, 3'd1, 4'd0, 1, 1);

      // Illegal jump: 001 (1) -> 111 (5) -> 101 (6)
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b1, 1'b1, 3'b001);
      chk_all("jump_base", 3'd1, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b1, 3'b111);
      chk_all("jump_err", 3'd5, 0, 1, 3'd0, 4'd1, 0, 1);
      cyc(1'b1, 1'b1, 3'b101);
      chk_all("jump_next", 3'd6, 1, 0, 3'd0, 4'd1, 0, 1);

      // Repeat and gaps: 011 (2), 011 again, then Valid=0 with Gray toggling
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b1, 1'b1, 3'b011);
      chk_all("rep_base", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b1, 3'b011);
      chk_all("rep_same", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b0, 3'b010);
      chk_all("gap_1", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b0, 3'b101);
      chk_all("gap_2", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b0, 3'b000);
      chk_all("gap_3", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);

      // Backward step: 011 (2) -> 001 (1)
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b1, 1'b1, 3'b011);
      chk_all("back_base", 3'd2, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b1, 3'b001);
      chk_all("back_err", 3'd1, 0, 1, 3'd0, 4'd1, 0, 1);

      // Crossing zero by a jump is an error, not a wrap: 100 (7) -> 001 (1)
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b1, 1'b1, 3'b100);
      cyc(1'b1, 1'b1, 3'b001);
      chk_all("cross_err", 3'd1, 0, 1, 3'd0, 4'd1, 0, 1);

      // Wrap saturation: 9 full wraps
      cyc(1'b0, 1'b0, 3'b000);
      cyc(1'b1, 1'b1, 3'b000);
      for (int w = 1; w <= 9; w++) begin
         for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b1, gseq[i]);
         end
         chk_all($sformatf("wrap_%0d", w), 3'd0, 1, 0, 3'((w > 7) ? 7 : w), 4'd0, 1, 1);
      end

      // Error saturation: 20 errors alternating 110 (4) and 000 (0)
      for (int e = 1; e <= 20; e++) begin
         cyc(1'b1, 1'b1, (e % 2 == 1) ? 3'b110 : 3'b000);
         chk_all($sformatf("err_%0d", e), (e % 2 == 1) ? 3'd4 : 3'd0, 0, 1, 3'd7,
                 4'((e > 15) ? 15 : e), 1, 1);
      end

      // Reset mid-operation has priority over Valid
      cyc(1'b0, 1'b1, 3'b001);
      chk_all("rst_mid", 3'd0, 0, 0, 3'd0, 4'd0, 0, 0);
      cyc(1'b1, 1'b1, 3'b110);
      chk_all("relock", 3'd4, 0, 0, 3'd0, 4'd0, 0, 1);
      cyc(1'b1, 1'b1, 3'b111);
      chk_all("relock_step", 3'd5, 1, 0, 3'd0, 4'd0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
